// File: rtl/apd_hv_sequencer_if.sv
// -----------------------------------------------------------------------------
// apd_hv_sequencer_if
//
// Bundles the request handshakes, the DAC write/done handshake and the status
// outputs of the APD high-voltage sequencer. clk and rst stay as plain ports on
// the sequencer itself.
//
// Handshake semantics: a request on either requester path is transferred in
// any cycle where its valid and ready are both high; the requester must hold
// code stable while valid is high. On the DAC side, dac_wr is a one-cycle
// strobe with dac_word valid from that cycle until the next write, and the
// driver answers with a one-cycle dac_done pulse when the write completes.
//
// Modports:
//   slave  - the sequencer (consumes requests, produces DAC writes and status)
//   master - the environment (requesters, DAC driver, status observers)
// -----------------------------------------------------------------------------
interface apd_hv_sequencer_if;
    logic        man_valid;
    logic [9:0]  man_code;
    logic        man_ready;
    logic        man_lock;
    logic        tc_valid;
    logic [9:0]  tc_code;
    logic        tc_ready;
    logic        dac_wr;
    logic [15:0] dac_word;
    logic        dac_done;
    logic [9:0]  cur_code;
    logic [9:0]  target_code;
    logic        settled;
    logic        err_clamp;
    logic        err_timeout;

    modport slave (
        input  man_valid, man_code, man_lock, tc_valid, tc_code, dac_done,
        output man_ready, tc_ready, dac_wr, dac_word, cur_code, target_code,
               settled, err_clamp, err_timeout
    );

    modport master (
        output man_valid, man_code, man_lock, tc_valid, tc_code, dac_done,
        input  man_ready, tc_ready, dac_wr, dac_word, cur_code, target_code,
               settled, err_clamp, err_timeout
    );
endinterface

// File: rtl/apd_hv_sequencer.sv
// -----------------------------------------------------------------------------
// apd_hv_sequencer
//
// Arbitrates bias-code requests from the host manual path and the temperature
// compensation path, clamps them to [CODE_MIN, CODE_MAX] and walks the APD HV
// DAC toward the clamped target in steps of at most STEP_MAX codes. Each step
// is one formatted DAC write; writes are paced by the DAC driver's done pulse
// (bounded by TIMEOUT_CYCLES) followed by a GAP_CYCLES idle gap.
//
// Ports:
//   clk        - sole clock
//   rst        - synchronous active-high reset
//   bus        - apd_hv_sequencer_if.slave: requests, DAC handshake, status
//   state_dbg  - current FSM state (0 IDLE, 1 WAIT_DONE, 2 GAP) for observation
// -----------------------------------------------------------------------------
module apd_hv_sequencer #(
    parameter int CODE_INIT      = 540,
    parameter int CODE_MIN       = 400,
    parameter int CODE_MAX       = 680,
    parameter int STEP_MAX       = 16,
    parameter int GAP_CYCLES     = 100_000,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    apd_hv_sequencer_if.slave     bus,
    output logic [1:0]            state_dbg
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [9:0]       C_INIT   = 10'(CODE_INIT);
    localparam logic [9:0]       C_MIN    = 10'(CODE_MIN);
    localparam logic [9:0]       C_MAX    = 10'(CODE_MAX);
    localparam logic [9:0]       C_STEP   = 10'(STEP_MAX);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_t;

    function automatic logic [15:0] fmt_word(input logic [9:0] code);
        return {1'b1, 3'b000, code, 2'b00};
    endfunction

    function automatic logic [9:0] clamp_code(input logic [9:0] code);
        if (code < C_MIN)
            return C_MIN;
        else if (code > C_MAX)
            return C_MAX;
        else
            return code;
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic             init_pend;
    logic [9:0]       cur_code;
    logic [9:0]       target_code;
    logic [15:0]      dac_word;
    logic             dac_wr;
    logic             err_clamp;
    logic             err_timeout;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;

    // ---------------------------------------------------------------
    // Request arbitration and clamp
    // ---------------------------------------------------------------
    logic       man_acc;
    logic       tc_acc;
    logic       req_take;
    logic [9:0] req_raw;
    logic [9:0] req_clamped;
    logic       req_oor;

    // Manual priority falls out of tc_ready being low whenever man_valid is.
    assign bus.man_ready = ~rst;
    assign bus.tc_ready  = ~bus.man_valid & ~rst;

    assign man_acc     = bus.man_valid & bus.man_ready;
    assign tc_acc      = bus.tc_valid & bus.tc_ready;
    // A tc request under manual lock is still handshaken, just discarded.
    assign req_take    = man_acc | (tc_acc & ~bus.man_lock);
    assign req_raw     = man_acc ? bus.man_code : bus.tc_code;
    assign req_clamped = clamp_code(req_raw);
    assign req_oor     = (req_clamped != req_raw);

    // ---------------------------------------------------------------
    // Slew-limited next code
    // ---------------------------------------------------------------
    logic       need_step;
    logic [9:0] diff;
    logic [9:0] next_code;

    assign need_step = init_pend | (cur_code != target_code);

    always_comb begin
        diff      = '0;
        next_code = cur_code;
        if (target_code > cur_code) begin
            diff      = target_code - cur_code;
            next_code = cur_code + ((diff > C_STEP) ? C_STEP : diff);
        end else if (target_code < cur_code) begin
            diff      = cur_code - target_code;
            next_code = cur_code - ((diff > C_STEP) ? C_STEP : diff);
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    logic issue_wr;
    logic load_gap;
    logic tmo_fire;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue_wr  = 1'b0;
        load_gap  = 1'b0;
        tmo_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (need_step) begin
                    issue_wr  = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A done coinciding with our own strobe belongs to an older
                // write, so it is not taken as completion.
                if (bus.dac_done && !dac_wr) begin
                    load_gap  = 1'b1;
                    state_nxt = GAP;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_fire  = 1'b1;
                    load_gap  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                // The last gap cycle issues the next step directly so the
                // write lands immediately after the gap.
                if (gap_cnt == '0) begin
                    if (need_step) begin
                        issue_wr  = 1'b1;
                        state_nxt = WAIT_DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            init_pend   <= 1'b1;
            cur_code    <= C_INIT;
            target_code <= C_INIT;
            dac_word    <= fmt_word(C_INIT);
            dac_wr      <= 1'b0;
            err_clamp   <= 1'b0;
            err_timeout <= 1'b0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            dac_wr      <= issue_wr;
            err_clamp   <= req_take & req_oor;
            err_timeout <= tmo_fire;

            if (req_take)
                target_code <= req_clamped;

            if (issue_wr) begin
                dac_word  <= fmt_word(next_code);
                cur_code  <= next_code;
                init_pend <= 1'b0;
                tmo_cnt   <= '0;
            end else if (state == WAIT_DONE) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (load_gap)
                gap_cnt <= GAP_LOAD;
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    assign bus.dac_wr      = dac_wr;
    assign bus.dac_word    = dac_word;
    assign bus.cur_code    = cur_code;
    assign bus.target_code = target_code;
    assign bus.err_clamp   = err_clamp;
    assign bus.err_timeout = err_timeout;
    assign bus.settled     = (state == IDLE) && (cur_code == target_code) && !init_pend;
    assign state_dbg       = state;

endmodule

// File: tb/tb_apd_hv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_apd_hv_sequencer
//
// Directed bench for apd_hv_sequencer with STEP_MAX=16, GAP_CYCLES=4,
// TIMEOUT_CYCLES=8. A DAC driver model answers each write with dac_done three
// cycles later (unless withheld); a monitor pops the expected DAC words from
// exp_q and checks write spacing.
// -----------------------------------------------------------------------------
module tb_apd_hv_sequencer;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] state_dbg;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apd_hv_sequencer_if sif ();

    apd_hv_sequencer #(
        .CODE_INIT      (540),
        .CODE_MIN       (400),
        .CODE_MAX       (680),
        .STEP_MAX       (16),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (sif),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;
    logic withhold_done = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [9:0] code);
        return {1'b1, 3'b000, code, 2'b00};
    endfunction

    task automatic push_code(input logic [9:0] code);
        exp_q.push_back(word_of(code));
    endtask

    // Expected walk: steps of up to 16 codes from 'from' to 'to'.
    task automatic push_walk(input int from, input int to);
        int c;
        c = from;
        while (c != to) begin
            if (to > c) c = c + ((to - c) > 16 ? 16 : (to - c));
            else        c = c - ((c - to) > 16 ? 16 : (c - to));
            push_code(10'(c));
        end
    endtask

    // ---------------- DAC driver model ----------------
    initial begin
        int done_cnt;
        done_cnt = 0;
        sif.dac_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sif.dac_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) sif.dac_done = 1'b1;
            end
            if (sif.dac_wr && !withhold_done) done_cnt = 3;
        end
    end

    // ---------------- write monitor ----------------
    initial begin
        int last_wr_cyc;
        logic [15:0] exp_w;
        last_wr_cyc = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_wr_cyc = -1;
            end else if (sif.dac_wr) begin
                check_eq("wr_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check_eq("dac_word", sif.dac_word, exp_w);
                end
                if (last_wr_cyc >= 0)
                    check_eq("wr_spacing_ge8", 32'((cyc - last_wr_cyc) >= 8), 1);
                last_wr_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_man(input logic [9:0] code);
        @(posedge clk); #1;
        sif.man_valid = 1'b1;
        sif.man_code  = code;
        @(negedge clk);
        check_eq("man_ready", sif.man_ready, 1);
        @(posedge clk); #1;
        sif.man_valid = 1'b0;
    endtask

    task automatic send_tc(input logic [9:0] code);
        @(posedge clk); #1;
        sif.tc_valid = 1'b1;
        sif.tc_code  = code;
        @(negedge clk);
        check_eq("tc_ready", sif.tc_ready, 1);
        @(posedge clk); #1;
        sif.tc_valid = 1'b0;
    endtask

    task automatic wait_settled(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sif.settled) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("settle_reached", ok, 1);
    endtask

    task automatic wait_wr(input int budget, output int w);
        logic ok;
        ok = 1'b0;
        w  = cyc;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sif.dac_wr) begin
                ok = 1'b1;
                w  = cyc;
                break;
            end
        end
        check_eq("wr_seen", ok, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_dac_wr"},      sif.dac_wr, 0);
        check_eq({tag, "_dac_word"},    sif.dac_word, 16'h8870);
        check_eq({tag, "_cur"},         sif.cur_code, 540);
        check_eq({tag, "_target"},      sif.target_code, 540);
        check_eq({tag, "_settled"},     sif.settled, 0);
        check_eq({tag, "_err_clamp"},   sif.err_clamp, 0);
        check_eq({tag, "_err_timeout"}, sif.err_timeout, 0);
        check_eq({tag, "_state"},       state_dbg, ST_IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w;
        sif.man_valid = 1'b0;
        sif.man_code  = '0;
        sif.man_lock  = 1'b0;
        sif.tc_valid  = 1'b0;
        sif.tc_code   = '0;

        // 1. Reset release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        check_eq("rst_man_ready", sif.man_ready, 0);
        check_eq("rst_tc_ready",  sif.tc_ready, 0);
        exp_q.push_back(16'h8870);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("c0_dac_wr", sif.dac_wr, 0);
        @(negedge clk);
        check_eq("c1_dac_wr", sif.dac_wr, 1);
        check_eq("c1_state",  state_dbg, ST_WAIT);
        wait_settled(40);
        check_eq("init_cur", sif.cur_code, 540);
        repeat (12) @(negedge clk);
        check_eq("init_still_settled", sif.settled, 1);

        // 2. Slew stepping up to 600
        exp_q.push_back(16'h88B0);
        exp_q.push_back(16'h88F0);
        exp_q.push_back(16'h8930);
        exp_q.push_back(16'h8960);
        send_man(600);
        @(negedge clk);
        check_eq("t2_target",    sif.target_code, 600);
        check_eq("t2_settled",   sif.settled, 0);
        check_eq("t2_err_clamp", sif.err_clamp, 0);
        wait_settled(100);
        check_eq("t2_cur", sif.cur_code, 600);

        // walk back down to 540
        push_walk(600, 540);
        send_man(540);
        wait_settled(100);
        check_eq("t2b_cur", sif.cur_code, 540);

        // 3. Simultaneous requests, then retarget during GAP
        push_code(524);
        @(posedge clk); #1;
        sif.man_valid = 1'b1; sif.man_code = 500;
        sif.tc_valid  = 1'b1; sif.tc_code  = 620;
        @(negedge clk);
        check_eq("t3_tc_ready",  sif.tc_ready, 0);
        check_eq("t3_man_ready", sif.man_ready, 1);
        @(posedge clk); #1;
        sif.man_valid = 1'b0;
        sif.tc_valid  = 1'b0;
        @(negedge clk);
        check_eq("t3_target", sif.target_code, 500);
        wait_wr(10, w);
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (state_dbg == ST_GAP) begin ok = 1'b1; break; end
            end
            check_eq("t3_gap_reached", ok, 1);
        end
        push_code(540);
        push_code(556);
        push_code(560);
        send_man(560);
        wait_settled(100);
        check_eq("t3_cur", sif.cur_code, 560);

        // 4. Lock and clamp
        sif.man_lock = 1'b1;
        send_tc(600);
        @(negedge clk);
        check_eq("t4_lock_target", sif.target_code, 560);
        repeat (10) @(negedge clk);
        check_eq("t4_lock_settled", sif.settled, 1);
        sif.man_lock = 1'b0;

        push_code(570);
        send_tc(570);
        @(negedge clk);
        check_eq("t4_tc_target", sif.target_code, 570);
        wait_settled(60);

        push_walk(570, 680);
        send_man(900);
        @(negedge clk);
        check_eq("t4_hi_target", sif.target_code, 680);
        check_eq("t4_hi_clamp",  sif.err_clamp, 1);
        @(negedge clk);
        check_eq("t4_hi_clamp_drop", sif.err_clamp, 0);
        wait_settled(300);
        check_eq("t4_hi_cur", sif.cur_code, 680);

        push_walk(680, 400);
        send_man(100);
        @(negedge clk);
        check_eq("t4_lo_target", sif.target_code, 400);
        check_eq("t4_lo_clamp",  sif.err_clamp, 1);
        wait_settled(400);
        check_eq("t4_lo_cur", sif.cur_code, 400);

        // 5. Missing done
        withhold_done = 1'b1;
        push_code(416);
        push_code(420);
        send_man(420);
        wait_wr(10, w);
        withhold_done = 1'b0;
        while (cyc < w + 7) @(negedge clk);
        check_eq("t5_no_tmo_early", sif.err_timeout, 0);
        check_eq("t5_state_wait",   state_dbg, ST_WAIT);
        @(negedge clk);
        check_eq("t5_tmo_pulse", sif.err_timeout, 1);
        check_eq("t5_state_gap", state_dbg, ST_GAP);
        check_eq("t5_cur_kept",  sif.cur_code, 416);
        @(negedge clk);
        check_eq("t5_tmo_drop", sif.err_timeout, 0);
        wait_wr(20, w);
        check_eq("t5_resume_cycle", 32'(w - cyc), 0);
        wait_settled(60);
        check_eq("t5_cur", sif.cur_code, 420);

        // 6. Reset mid-operation
        push_code(436);
        send_man(500);
        wait_wr(10, w);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_man_ready_rst", sif.man_ready, 0);
        check_eq("t6_tc_ready_rst",  sif.tc_ready, 0);
        @(negedge clk);
        check_reset_vals("t6");
        exp_q.push_back(16'h8870);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_late_done_seen", sif.dac_done, 1);
        check_eq("t6_c0_state",  state_dbg, ST_IDLE);
        check_eq("t6_c0_dac_wr", sif.dac_wr, 0);
        @(negedge clk);
        check_eq("t6_c1_dac_wr", sif.dac_wr, 1);
        @(negedge clk);
        check_eq("t6_c2_state", state_dbg, ST_WAIT);
        wait_settled(40);
        check_eq("t6_cur",    sif.cur_code, 540);
        check_eq("t6_target", sif.target_code, 540);

        repeat (5) @(negedge clk);
        check_eq("exp_q_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
